fp_operand_queue: RTL and testbench

Operand-pair FIFO that sits directly upstream of fp_mul. It accepts (a, b) operand pairs on a valid/ready push port and buffers them. It presents the head pair to fp_mul through fp_mul's independent stb/ack handshakes on input_a and input_b, and pops the pair only after both operands have been transferred. This decouples the operand source from fp_mul's multi-cycle, state-dependent acceptance.

---
 rtl/fp_operand_queue.sv | 133 +++++++++++++
 tb/tb_fp_operand_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_queue.sv
// rtl/fp_operand_queue.sv - operand-pair FIFO feeding fp_mul's split stb/ack inputs
//
// Purpose:
//   Buffers (a, b) operand pairs arriving on a valid/ready push port and
//   presents the head pair to fp_mul on two independent stb/ack handshakes.
//   A pair is popped only once both of its operands have been accepted.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   push_a, push_b            incoming operand pair
//   push_valid / push_ready   push handshake; ready depends on registered count only
//   input_a, input_a_stb      head operand a to fp_mul, and its strobe
//   input_a_ack               fp_mul accepts input_a
//   input_b, input_b_stb      head operand b to fp_mul, and its strobe
//   input_b_ack               fp_mul accepts input_b
//   count                     pairs currently held, 0..DEPTH
//   issued                    pairs fully delivered since reset, modulo 2^16

module fp_operand_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] push_a,
   input  logic [WIDTH-1:0] push_b,
   input  logic             push_valid,
   output logic             push_ready,
   output logic [WIDTH-1:0] input_a,
   output logic             input_a_stb,
   input  logic             input_a_ack,
   output logic [WIDTH-1:0] input_b,
   output logic             input_b_stb,
   input  logic             input_b_ack,
   output logic [CW-1:0]    count,
   output logic [15:0]      issued
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Storage is not reset: a cleared count makes any stale contents unreachable.
   logic [WIDTH-1:0] mem_a_q [DEPTH];
   logic [WIDTH-1:0] mem_b_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          a_done_q, a_done_d;
   logic          b_done_q, b_done_d;
   logic [15:0]   issued_q, issued_d;

   logic empty;
   logic push;
   logic a_xfer;
   logic b_xfer;
   logic pop;

   // ---------------------------------------------------------------
   // Handshake decode. Strobes come from registered state only, so an
   // ack can never combinationally feed back into a strobe or ready.
   // ---------------------------------------------------------------
   always_comb begin
      empty       = (count_q == '0);
      push_ready  = (count_q < DEPTH_C);
      push        = push_valid && push_ready;

      input_a_stb = !empty && !a_done_q;
      input_b_stb = !empty && !b_done_q;
      a_xfer      = input_a_stb && input_a_ack;
      b_xfer      = input_b_stb && input_b_ack;

      // Pop when each operand is either already delivered or delivering now;
      // this covers either order and the same-edge case.
      pop         = (a_done_q || a_xfer) && (b_done_q || b_xfer);

      input_a     = empty ? '0 : mem_a_q[rd_ptr_q];
      input_b     = empty ? '0 : mem_b_q[rd_ptr_q];

      count       = count_q;
      issued      = issued_q;
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

      // Done flags clear on pop so the next head is strobed with no gap.
      a_done_d = pop ? 1'b0 : (a_done_q || a_xfer);
      b_done_d = pop ? 1'b0 : (b_done_q || b_xfer);

      issued_d = pop ? issued_q + 16'd1 : issued_q;

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // ---------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         a_done_q <= 1'b0;
         b_done_q <= 1'b0;
         issued_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         a_done_q <= a_done_d;
         b_done_q <= b_done_d;
         issued_q <= issued_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a_q[wr_ptr_q] <= push_a;
         mem_b_q[wr_ptr_q] <= push_b;
      end
   end

endmodule

// File: tb/tb_fp_operand_queue.sv
// tb/tb_fp_operand_queue.sv - self-checking bench for fp_operand_queue

module tb_fp_operand_queue;

   localparam int W     = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic [W-1:0]  push_a, push_b;
   logic          push_valid, push_ready;
   logic [W-1:0]  input_a, input_b;
   logic          input_a_stb, input_b_stb;
   logic          input_a_ack, input_b_ack;
   logic [CW-1:0] count;
   logic [15:0]   issued;

   fp_operand_queue #(.WIDTH(W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .push_a(push_a), .push_b(push_b),
      .push_valid(push_valid), .push_ready(push_ready),
      .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
      .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
      .count(count), .issued(issued)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of pairs plus per-operand "already sent" flags.
   logic [2*W-1:0] mq[$];
   bit             m_a_sent, m_b_sent;
   logic [15:0]    m_issued;

   task automatic model_reset();
      mq.delete();
      m_a_sent = 0;
      m_b_sent = 0;
      m_issued = '0;
   endtask

   function automatic bit m_stb_a();
      return (mq.size() > 0) && !m_a_sent;
   endfunction

   function automatic bit m_stb_b();
      return (mq.size() > 0) && !m_b_sent;
   endfunction

   task automatic model_check();
      logic [W-1:0] ea, eb;
      ea = '0;
      eb = '0;
      if (mq.size() > 0) begin
         ea = mq[0][2*W-1:W];
         eb = mq[0][W-1:0];
      end
      chk("m_ready", 64'(push_ready), 64'(mq.size() < DEPTH));
      chk("m_stb_a", 64'(input_a_stb), 64'(m_stb_a()));
      chk("m_stb_b", 64'(input_b_stb), 64'(m_stb_b()));
      chk("m_in_a", 64'(input_a), 64'(ea));
      chk("m_in_b", 64'(input_b), 64'(eb));
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_issued", 64'(issued), 64'(m_issued));
   endtask

   // One clock: compare against model, drive inputs, advance model and DUT.
   task automatic step(input bit pv, input logic [W-1:0] pa, input logic [W-1:0] pb,
                       input bit aa, input bit ab);
      int  sz;
      bit  ax, bx;
      model_check();
      push_valid  = pv;
      push_a      = pa;
      push_b      = pb;
      input_a_ack = aa;
      input_b_ack = ab;
      sz = mq.size();
      ax = m_stb_a() && aa;
      bx = m_stb_b() && ab;
      if (ax) m_a_sent = 1;
      if (bx) m_b_sent = 1;
      if (m_a_sent && m_b_sent) begin
         void'(mq.pop_front());
         m_a_sent = 0;
         m_b_sent = 0;
         m_issued = m_issued + 16'd1;
      end
      if (pv && sz < DEPTH) mq.push_back({pa, pb});
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          pv;
      logic [W-1:0]  pa, pb;
      logic          aa, ab;
      logic [CW-1:0] e_cnt;
      logic          e_sa, e_sb, e_pr;
      logic [W-1:0]  e_ia, e_ib;
      logic [15:0]   e_iss;
   } vec_t;

   function automatic vec_t mk(int pv, int pa, int pb, int aa, int ab,
                               int cnt, int sa, int sb, int pr, int ia, int ib, int iss);
      vec_t v;
      v.pv = 1'(pv);  v.pa = W'(pa);  v.pb = W'(pb);
      v.aa = 1'(aa);  v.ab = 1'(ab);
      v.e_cnt = CW'(cnt); v.e_sa = 1'(sa); v.e_sb = 1'(sb); v.e_pr = 1'(pr);
      v.e_ia = W'(ia); v.e_ib = W'(ib); v.e_iss = 16'(iss);
      return v;
   endfunction

   vec_t tbl[20];

   logic [W-1:0] got_a[$];
   logic [W-1:0] got_b[$];

   initial begin
      int  next_push;
      int  cyc;
      bit  pv, aa, ab;

      // Split acks, same-edge acks, full queue, ignored ack, push+pop together.
      tbl[0]  = mk(1, 32'h3FC00000, 32'h40000000, 0, 0, 1, 1, 1, 1, 32'h3FC00000, 32'h40000000, 0);
      tbl[1]  = mk(0, 0, 0, 1, 0, 1, 0, 1, 1, 32'h3FC00000, 32'h40000000, 0);
      tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 32'h3FC00000, 32'h40000000, 0);
      tbl[3]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1);
      tbl[4]  = mk(1, 1, 2, 0, 0, 1, 1, 1, 1, 1, 2, 1);
      tbl[5]  = mk(1, 3, 4, 0, 0, 2, 1, 1, 1, 1, 2, 1);
      tbl[6]  = mk(0, 0, 0, 1, 1, 1, 1, 1, 1, 3, 4, 2);
      tbl[7]  = mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 3);
      tbl[8]  = mk(1, 10, 20, 0, 0, 1, 1, 1, 1, 10, 20, 3);
      tbl[9]  = mk(1, 11, 21, 0, 0, 2, 1, 1, 1, 10, 20, 3);
      tbl[10] = mk(1, 12, 22, 0, 0, 3, 1, 1, 1, 10, 20, 3);
      tbl[11] = mk(1, 13, 23, 0, 0, 4, 1, 1, 0, 10, 20, 3);
      tbl[12] = mk(1, 99, 99, 0, 0, 4, 1, 1, 0, 10, 20, 3);
      tbl[13] = mk(0, 0, 0, 1, 0, 4, 0, 1, 0, 10, 20, 3);
      tbl[14] = mk(0, 0, 0, 1, 0, 4, 0, 1, 0, 10, 20, 3);
      tbl[15] = mk(0, 0, 0, 0, 1, 3, 1, 1, 1, 11, 21, 4);
      tbl[16] = mk(1, 50, 60, 1, 1, 3, 1, 1, 1, 12, 22, 5);
      tbl[17] = mk(0, 0, 0, 1, 1, 2, 1, 1, 1, 13, 23, 6);
      tbl[18] = mk(0, 0, 0, 1, 1, 1, 1, 1, 1, 50, 60, 7);
      tbl[19] = mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 8);

      rst = 1'b1;
      push_valid = 1'b0; push_a = '0; push_b = '0;
      input_a_ack = 1'b0; input_b_ack = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ready", 64'(push_ready), 64'd1);
      chk("rst_stb_a", 64'(input_a_stb), 64'd0);
      chk("rst_stb_b", 64'(input_b_stb), 64'd0);
      chk("rst_in_a", 64'(input_a), 64'd0);
      chk("rst_issued", 64'(issued), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 20; i++) begin
         step(tbl[i].pv, tbl[i].pa, tbl[i].pb, tbl[i].aa, tbl[i].ab);
         chk($sformatf("t%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
         chk($sformatf("t%0d_stb_a", i), 64'(input_a_stb), 64'(tbl[i].e_sa));
         chk($sformatf("t%0d_stb_b", i), 64'(input_b_stb), 64'(tbl[i].e_sb));
         chk($sformatf("t%0d_ready", i), 64'(push_ready), 64'(tbl[i].e_pr));
         chk($sformatf("t%0d_in_a", i), 64'(input_a), 64'(tbl[i].e_ia));
         chk($sformatf("t%0d_in_b", i), 64'(input_b), 64'(tbl[i].e_ib));
         chk($sformatf("t%0d_issued", i), 64'(issued), 64'(tbl[i].e_iss));
      end

      // Reset mid-transfer: three pairs held, a already delivered for the head.
      step(1, 32'h111, 32'h211, 0, 0);
      step(1, 32'h112, 32'h212, 0, 0);
      step(1, 32'h113, 32'h213, 0, 0);
      step(0, 0, 0, 1, 0);
      chk("pre_rst_count", 64'(count), 64'd3);
      chk("pre_rst_stb_a", 64'(input_a_stb), 64'd0);
      rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_stb_a", 64'(input_a_stb), 64'd0);
      chk("async_rst_stb_b", 64'(input_b_stb), 64'd0);
      chk("async_rst_count", 64'(count), 64'd0);
      chk("async_rst_issued", 64'(issued), 64'd0);
      chk("async_rst_ready", 64'(push_ready), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_valid = 1'b0;
      input_a_ack = 1'b0;
      input_b_ack = 1'b0;

      // Ten pairs with random push gaps and random ack delays.
      next_push = 0;
      cyc = 0;
      while (m_issued < 16'd10 && cyc < 600) begin
         pv = (next_push < 10) && ($urandom_range(0, 3) != 0);
         aa = ($urandom_range(0, 2) == 0);
         ab = ($urandom_range(0, 2) == 0);
         if (input_a_stb && aa) got_a.push_back(input_a);
         if (input_b_stb && ab) got_b.push_back(input_b);
         if (pv && mq.size() < DEPTH) begin
            step(1, W'(next_push), W'(100 + next_push), aa, ab);
            next_push++;
         end else begin
            step(0, W'($urandom), W'($urandom), aa, ab);
         end
         cyc++;
      end
      chk("stream_done", 64'(m_issued == 16'd10), 64'd1);
      chk("stream_got_a", 64'(got_a.size()), 64'd10);
      chk("stream_got_b", 64'(got_b.size()), 64'd10);
      for (int i = 0; i < 10; i++) begin
         if (i < got_a.size()) chk($sformatf("order_a%0d", i), 64'(got_a[i]), 64'(i));
         if (i < got_b.size()) chk($sformatf("order_b%0d", i), 64'(got_b[i]), 64'(100 + i));
      end
      chk("stream_issued", 64'(issued), 64'd10);
      chk("stream_count", 64'(count), 64'd0);

      // Run the issued counter up to 0xFFFF and across the wrap.
      cyc = 0;
      while (m_issued != 16'hFFFF && cyc < 70000) begin
         step(1, W'(cyc), W'(~cyc), 1, 1);
         cyc++;
      end
      chk("issued_ffff", 64'(issued), 64'hFFFF);
      cyc = 0;
      while (m_issued == 16'hFFFF && cyc < 10) begin
         step(1, W'(cyc), W'(cyc), 1, 1);
         cyc++;
      end
      chk("issued_wrap", 64'(issued), 64'h0000);
      cyc = 0;
      while (mq.size() > 0 && cyc < 20) begin
         step(0, 0, 0, 1, 1);
         cyc++;
      end
      model_check();
      chk("final_count", 64'(count), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
